// File: rtl/led_mode_ctrl.sv
// Push-button mode controller: debounced presses step OFF->ON->SLOW->FAST->OFF, LED blinks in SLOW/FAST.
// Press-to-mode latency: 2 sync clk + DB_TICKS ticks + 2 clk; no backpressure, button input is free-running.
module led_mode_ctrl #(
   parameter int TICK_DIV  = 100000,
   parameter int DB_TICKS  = 20,
   parameter int SLOW_HALF = 500,
   parameter int FAST_HALF = 125
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn,
   output logic [1:0] led,
   output logic [1:0] mode,
   output logic       tick
);

   localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW   = $clog2(DB_TICKS + 1);
   localparam int HMAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
   localparam int BW   = $clog2(HMAX + 1);

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DB_LAST    = DW'(DB_TICKS - 1);
   localparam logic [BW-1:0] SLOW_LAST  = BW'(SLOW_HALF - 1);
   localparam logic [BW-1:0] FAST_LAST  = BW'(FAST_HALF - 1);

   typedef enum logic [1:0] {
      MODE_OFF  = 2'd0,
      MODE_ON   = 2'd1,
      MODE_SLOW = 2'd2,
      MODE_FAST = 2'd3
   } mode_e;

   logic [PW-1:0] r_presc;
   logic          r_sync1;
   logic          r_sync2;
   logic          r_btn_db;
   logic [DW-1:0] r_db_cnt;
   logic          r_db_prev;
   logic          r_press;
   mode_e         r_state;
   mode_e         w_state_nxt;
   logic [BW-1:0] r_blink_cnt;
   logic          r_phase;
   logic          w_tick;
   logic          w_led0;
   logic          w_blinking;
   logic [BW-1:0] w_half_last;

   assign w_tick = (r_presc == PRESC_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= btn;
         r_sync2 <= r_sync1;
      end
   end

   // Counter only advances while the synchronized level disagrees; any agreement restarts it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_btn_db <= 1'b0;
         r_db_cnt <= '0;
      end else if (r_sync2 == r_btn_db) begin
         r_db_cnt <= '0;
      end else if (w_tick) begin
         if (r_db_cnt == DB_LAST) begin
            r_btn_db <= r_sync2;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + DW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_db_prev <= 1'b0;
         r_press   <= 1'b0;
      end else begin
         r_db_prev <= r_btn_db;
         r_press   <= r_btn_db & ~r_db_prev;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= MODE_OFF;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_led0      = 1'b0;
      case (r_state)
         MODE_OFF: begin
            w_led0 = 1'b0;
            if (r_press) w_state_nxt = MODE_ON;
         end
         MODE_ON: begin
            w_led0 = 1'b1;
            if (r_press) w_state_nxt = MODE_SLOW;
         end
         MODE_SLOW: begin
            w_led0 = r_phase;
            if (r_press) w_state_nxt = MODE_FAST;
         end
         MODE_FAST: begin
            w_led0 = r_phase;
            if (r_press) w_state_nxt = MODE_OFF;
         end
         default: begin
            w_state_nxt = MODE_OFF;
         end
      endcase
   end

   assign w_blinking  = (r_state == MODE_SLOW) || (r_state == MODE_FAST);
   assign w_half_last = (r_state == MODE_SLOW) ? SLOW_LAST : FAST_LAST;

   // Every press is a mode change, so it restarts the blink phase even if a tick coincides.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b1;
      end else if (r_press || !w_blinking) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b1;
      end else if (w_tick) begin
         if (r_blink_cnt == w_half_last) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
         end
      end
   end

   assign tick = w_tick;
   assign led  = {r_btn_db, w_led0};
   assign mode = r_state;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with TICK_DIV=4, DB_TICKS=3, SLOW_HALF=5, FAST_HALF=2.
module tb_led_mode_ctrl;

   logic       clk;
   logic       rst;
   logic       btn;
   logic [1:0] led;
   logic [1:0] mode;
   logic       tick;

   int n_tests = 0;
   int n_fail  = 0;

   led_mode_ctrl #(
      .TICK_DIV (4),
      .DB_TICKS (3),
      .SLOW_HALF(5),
      .FAST_HALF(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .btn (btn),
      .led (led),
      .mode(mode),
      .tick(tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press_btn(output int ticks, output bit timed_out);
      logic t;
      btn = 1'b1;
      step();
      step();
      ticks     = 0;
      timed_out = 1'b1;
      for (int k = 0; k < 100; k++) begin
         t = tick;
         step();
         if (t) ticks++;
         if (led[1]) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic release_btn(output bit timed_out);
      btn       = 1'b0;
      timed_out = 1'b1;
      for (int k = 0; k < 100; k++) begin
         step();
         if (!led[1]) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      btn = 1'b0;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (led !== 2'b00) begin n_fail++; $display("FAIL reset_led: got %b expected 00", led); end
      n_tests++;
      if (mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode: got %0d expected 0", mode); end
      n_tests++;
      if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", tick); end
   endtask

   task automatic test_tick();
      logic exp_t;
      #4 rst = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         step();
         exp_t = ((n % 4) == 3);
         n_tests++;
         if (tick !== exp_t) begin n_fail++; $display("FAIL tick_edge%0d: got %b expected %b", n, tick, exp_t); end
         n_tests++;
         if ({led, mode} !== 4'b0000) begin n_fail++; $display("FAIL idle_out_edge%0d: got led=%b mode=%0d expected led=00 mode=0", n, led, mode); end
      end
   endtask

   task automatic test_bounce();
      bit seen_db = 1'b0;
      for (int r = 0; r < 5; r++) begin
         btn = 1'b1;
         for (int k = 0; k < 8; k++) begin step(); if (led[1]) seen_db = 1'b1; end
         btn = 1'b0;
         for (int k = 0; k < 8; k++) begin step(); if (led[1]) seen_db = 1'b1; end
         n_tests++;
         if ({led, mode} !== 4'b0000) begin n_fail++; $display("FAIL bounce_rep%0d: got led=%b mode=%0d expected led=00 mode=0", r, led, mode); end
      end
      n_tests++;
      if (seen_db !== 1'b0) begin n_fail++; $display("FAIL bounce_db_seen: got %b expected 0", seen_db); end
   endtask

   task automatic test_press();
      int ticks;
      bit to;
      bit moved = 1'b0;
      press_btn(ticks, to);
      n_tests++;
      if (to !== 1'b0) begin n_fail++; $display("FAIL press_timeout: got %b expected 0", to); end
      n_tests++;
      if (ticks != 3) begin n_fail++; $display("FAIL press_db_ticks: got %0d expected 3", ticks); end
      step();
      n_tests++;
      if (mode !== 2'd0) begin n_fail++; $display("FAIL press_mode_e1: got %0d expected 0", mode); end
      step();
      n_tests++;
      if (mode !== 2'd1) begin n_fail++; $display("FAIL press_mode_e2: got %0d expected 1", mode); end
      n_tests++;
      if (led !== 2'b11) begin n_fail++; $display("FAIL press_led: got %b expected 11", led); end
      for (int k = 0; k < 40; k++) begin step(); if (mode !== 2'd1) moved = 1'b1; end
      n_tests++;
      if (moved !== 1'b0) begin n_fail++; $display("FAIL press_single: got extra mode change %b expected 0", moved); end
   endtask

   task automatic test_modes();
      int ticks;
      int gap;
      int first_gap;
      int period;
      bit to;
      logic [1:0] tgt;
      logic [1:0] prev_mode;
      logic [1:0] exp_led;
      logic prev_led0;
      logic exp_led0;
      for (int i = 0; i < 3; i++) begin
         tgt       = (i == 0) ? 2'd2 : ((i == 1) ? 2'd3 : 2'd0);
         exp_led   = (i == 2) ? 2'b10 : 2'b11;
         prev_mode = mode;
         release_btn(to);
         n_tests++;
         if (to !== 1'b0) begin n_fail++; $display("FAIL modes_release_timeout%0d: got %b expected 0", i, to); end
         n_tests++;
         if (mode !== prev_mode) begin n_fail++; $display("FAIL modes_release_mode%0d: got %0d expected %0d", i, mode, prev_mode); end
         press_btn(ticks, to);
         n_tests++;
         if (to !== 1'b0 || ticks != 3) begin n_fail++; $display("FAIL modes_press%0d: got timeout=%b ticks=%0d expected 0/3", i, to, ticks); end
         step();
         n_tests++;
         if (mode !== prev_mode) begin n_fail++; $display("FAIL modes_early%0d: got %0d expected %0d", i, mode, prev_mode); end
         step();
         n_tests++;
         if (mode !== tgt) begin n_fail++; $display("FAIL modes_mode%0d: got %0d expected %0d", i, mode, tgt); end
         n_tests++;
         if (led !== exp_led) begin n_fail++; $display("FAIL modes_led%0d: got %b expected %b", i, led, exp_led); end
         if (tgt != 2'd0) begin
            first_gap = (tgt == 2'd2) ? 18 : 6;
            period    = (tgt == 2'd2) ? 20 : 8;
            for (int g = 0; g < 3; g++) begin
               prev_led0 = led[0];
               gap = 0;
               for (int k = 1; k <= 60; k++) begin
                  step();
                  if (led[0] !== prev_led0) begin gap = k; break; end
               end
               exp_led0 = (g == 1);
               n_tests++;
               if (gap != ((g == 0) ? first_gap : period)) begin
                  n_fail++;
                  $display("FAIL blink_gap_m%0d_g%0d: got %0d clk expected %0d clk", tgt, g, gap, (g == 0) ? first_gap : period);
               end
               n_tests++;
               if (led[0] !== exp_led0) begin n_fail++; $display("FAIL blink_level_m%0d_g%0d: got %b expected %b", tgt, g, led[0], exp_led0); end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int ticks;
      bit to;
      bit to_any = 1'b0;
      bit moved = 1'b0;
      logic t;
      for (int i = 0; i < 2; i++) begin
         release_btn(to);
         to_any |= to;
         press_btn(ticks, to);
         to_any |= to;
         step();
         step();
      end
      release_btn(to);
      to_any |= to;
      n_tests++;
      if (to_any !== 1'b0 || mode !== 2'd2) begin n_fail++; $display("FAIL rmid_setup: got timeout=%b mode=%0d expected 0/2", to_any, mode); end
      btn = 1'b1;
      step();
      step();
      ticks = 0;
      for (int k = 0; k < 40; k++) begin
         t = tick;
         step();
         if (t) ticks++;
         if (ticks == 2) break;
      end
      n_tests++;
      if (ticks != 2 || led[1] !== 1'b0) begin n_fail++; $display("FAIL rmid_half: got ticks=%0d db=%b expected 2/0", ticks, led[1]); end
      #2 rst = 1'b0;
      #1;
      n_tests++;
      if ({led, mode, tick} !== 5'b00000) begin n_fail++; $display("FAIL rmid_async: got led=%b mode=%0d tick=%b expected all 0", led, mode, tick); end
      step();
      step();
      n_tests++;
      if ({led, mode, tick} !== 5'b00000) begin n_fail++; $display("FAIL rmid_held: got led=%b mode=%0d tick=%b expected all 0", led, mode, tick); end
      #4 rst = 1'b1;
      for (int n = 1; n <= 14; n++) begin
         step();
         if (n <= 11) begin
            n_tests++;
            if ({led, mode} !== 4'b0000) begin n_fail++; $display("FAIL rmid_edge%0d: got led=%b mode=%0d expected 00/0", n, led, mode); end
         end else if (n <= 13) begin
            n_tests++;
            if ({led, mode} !== 4'b1000) begin n_fail++; $display("FAIL rmid_edge%0d: got led=%b mode=%0d expected 10/0", n, led, mode); end
         end else begin
            n_tests++;
            if ({led, mode} !== 4'b1101) begin n_fail++; $display("FAIL rmid_edge%0d: got led=%b mode=%0d expected 11/1", n, led, mode); end
         end
      end
      for (int k = 0; k < 60; k++) begin step(); if (mode !== 2'd1) moved = 1'b1; end
      n_tests++;
      if (moved !== 1'b0) begin n_fail++; $display("FAIL rmid_single_press: got extra mode change %b expected 0", moved); end
   endtask

   initial begin
      test_reset();
      test_tick();
      test_bounce();
      test_press();
      test_modes();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/led_mode_ctrl.md
LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000: clk cycles per tick (1 kHz at 100 MHz); legal range >= 2.
REQ-002 Parameter DB_TICKS, default 20: consecutive ticks a changed button level must hold before acceptance; legal range >= 1.
REQ-003 Parameter SLOW_HALF, default 500: ticks per half-period in SLOW mode; legal range >= 1.
REQ-004 Parameter FAST_HALF, default 125: ticks per half-period in FAST mode; legal range >= 1.
REQ-005 Port clk, input, 1: single clock; all state on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-low reset.
REQ-007 Port btn, input, 1: raw, asynchronous, bouncing push-button, high = pressed.
REQ-008 Port led, output, 2: led[0] = mode-driven LED; led[1] = debounced button level.
REQ-009 Port mode, output, 2: current mode encoding, OFF=0, ON=1, SLOW=2, FAST=3.
REQ-010 Port tick, output, 1: prescaler strobe, high for one clk per TICK_DIV cycles.

Function
REQ-011 Prescaler counts 0..TICK_DIV-1 and wraps to 0; tick SHALL be high exactly in the cycle the count equals TICK_DIV-1.
REQ-012 btn SHALL pass through a 2-flop synchronizer; the synchronized level appears 2 clk after a btn change.
REQ-013 Debouncer holds accepted level btn_db; while synchronized level equals btn_db its tick counter SHALL be 0.
REQ-014 While synchronized level differs from btn_db, counter SHALL increment on each tick; on the tick making it DB_TICKS, btn_db SHALL take the synchronized level and the counter SHALL clear.
REQ-015 Any return of the synchronized level to btn_db before acceptance SHALL clear the counter (bounce rejection).
REQ-016 press pulse SHALL be high for exactly one clk, in the cycle after btn_db changes 0->1; a 1->0 change SHALL produce no pulse.
REQ-017 Mode FSM SHALL advance OFF->ON->SLOW->FAST->OFF, one step per press pulse; no other transitions.
REQ-018 Blink engine: phase bit plus tick counter; in SLOW/FAST the counter SHALL increment per tick and, on the tick reaching HALF (SLOW_HALF or FAST_HALF), phase SHALL invert and the counter clear.
REQ-019 In the cycle a mode transition is registered, blink counter SHALL clear and phase SHALL be set to 1; a coincident tick SHALL be ignored by the blink engine (mode change wins).
REQ-020 In OFF and ON, blink counter SHALL hold 0 and phase 1.
REQ-021 led[0] SHALL be 0 in OFF, 1 in ON, phase in SLOW/FAST; led[1] SHALL equal btn_db; both registered-state derived, no combinational path from btn.
REQ-022 Counter widths SHALL be sized by $clog2 of their parameter maxima; no counter may overflow or wrap other than as specified.

Reset
REQ-023 rst low SHALL asynchronously force: prescaler 0, synchronizer flops 0, btn_db 0, debounce counter 0, press 0, mode OFF, blink counter 0, phase 1.
REQ-024 Outputs during reset: led=2'b00, mode=0, tick=0.
REQ-025 Release SHALL be synchronous-safe: first tick occurs TICK_DIV clk after the first rising edge with rst high.
REQ-026 Reset asserted mid-debounce or mid-blink SHALL discard all progress; no press pulse generated from a pre-reset level.

Verification (TICK_DIV=4, DB_TICKS=3, SLOW_HALF=5, FAST_HALF=2)
REQ-027 Reset release, btn=0 -> tick high on clk 4, 8, 12...; led=00, mode=0 throughout.
REQ-028 btn held 1 -> btn_db and led[1] rise on the third tick after sync level changes; one press; mode=1, led[0]=1.
REQ-029 btn pulses 1 for 2 ticks then 0, repeated 5 times -> btn_db never changes, mode stays 0.
REQ-030 Three clean presses from OFF -> mode 1, 2, 3; in mode 2 led[0] toggles every 20 clk, in mode 3 every 8 clk, starting at 1 after each change.
REQ-031 Fourth press -> mode 0, led[0]=0; press landing in a tick cycle -> blink counter 0, phase 1, next toggle a full half-period later.
REQ-032 rst pulsed low during mode 2 with btn debounce half complete -> all outputs zero; after release, button still held produces exactly one press after 3 ticks, mode=1.
